// File: rtl/apb_bridge_pkg.sv
// Shared AHB-to-APB bridge types and elaboration helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package apb_bridge_pkg;

   // Read-data packer state; IDLE must encode as 0.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } rd_state_e;

   // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Number of bytes moved by an AHB transfer of the given HSIZE.
   function automatic int hsize_bytes(input logic [2:0] hsize);
      return 1 << hsize;
   endfunction

endpackage

// File: rtl/apb_rdata_packer_if.sv
// Bus bundle between the APB master/AHB side and the read-data packer.
// Latency: n/a (wires only).
// Backpressure: none; the packer only observes the APB bus.
interface apb_rdata_packer_if
   import apb_bridge_pkg::*;
#(
   parameter int AHB_DW = 32,
   parameter int APB_DW = 8
);
   localparam int RATIO  = AHB_DW / APB_DW;
   localparam int LANE_W = (RATIO > 1) ? clog2(RATIO) : 1;

   logic              i_start;
   logic [2:0]        i_hsize;
   logic [LANE_W-1:0] i_haddr_lane;
   logic              i_PSEL;
   logic              i_PENABLE;
   logic              i_PWRITE;
   logic              i_PREADY;
   logic              i_PSLVERR;
   logic [APB_DW-1:0] i_PRDATA;
   logic [AHB_DW-1:0] o_HRDATA;
   logic              o_rdata_valid;
   logic              o_rdata_err;
   logic              o_busy;
   logic              o_abort;

   modport master (
      output i_start, i_hsize, i_haddr_lane,
      output i_PSEL, i_PENABLE, i_PWRITE, i_PREADY, i_PSLVERR, i_PRDATA,
      input  o_HRDATA, o_rdata_valid, o_rdata_err, o_busy, o_abort
   );

   modport slave (
      input  i_start, i_hsize, i_haddr_lane,
      input  i_PSEL, i_PENABLE, i_PWRITE, i_PREADY, i_PSLVERR, i_PRDATA,
      output o_HRDATA, o_rdata_valid, o_rdata_err, o_busy, o_abort
   );
endinterface

// File: rtl/apb_rdata_packer_rdata_lane_demux.sv
// Decodes the current APB lane index into one-hot write strobes for the shadow word.
// Latency: combinational.
// Backpressure: none; strobes are all-zero when en_i is low.
module rdata_lane_demux #(
   parameter int RATIO  = 4,
   parameter int LANE_W = 2
) (
   input  logic [LANE_W-1:0] lane_i,
   input  logic              en_i,
   output logic [RATIO-1:0]  strb_o
);

   // One strobe per lane, raised only for the selected lane on an accepted beat.
   always_comb begin
      strb_o = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (en_i && (lane_i == LANE_W'(i))) strb_o[i] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_rdata_packer.sv
// Packs APB read beats into an AHB-wide HRDATA word; APB_RDATA_ERR_ABORT_EN ends a read on the first PSLVERR.
// Latency: word, valid and error register on the edge that accepts the last beat.
// Backpressure: follows the APB bus; wait states (PREADY=0) simply stall collection.
module apb_rdata_packer
   import apb_bridge_pkg::*;
#(
   parameter int AHB_DW = 32,
   parameter int APB_DW = 8
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   apb_rdata_packer_if.slave bus
);
   localparam int APB_DW_B = APB_DW / 8;
   localparam int RATIO    = AHB_DW / APB_DW;
   localparam int LANE_W   = (RATIO > 1) ? clog2(RATIO) : 1;
   localparam int REM_W    = clog2(RATIO + 1);

   rd_state_e         state_q, state_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic              err_q, err_d;
   logic [AHB_DW-1:0] shadow_q, shadow_d;
   logic [AHB_DW-1:0] hrdata_q, hrdata_d;
   logic              valid_q, valid_d;
   logic              rerr_q, rerr_d;
   logic              abort_d;
   logic              accept;
   logic              end_xfer;
   logic [RATIO-1:0]  strb;
   logic [AHB_DW-1:0] merged;
   logic [REM_W-1:0]  start_beats;
   int                beats_int;

   assign accept = (state_q == ST_COLLECT) & bus.i_PSEL & bus.i_PENABLE
                 & bus.i_PREADY & ~bus.i_PWRITE;

   rdata_lane_demux #(
      .RATIO  (RATIO),
      .LANE_W (LANE_W)
   ) u_demux (
      .lane_i (lane_q),
      .en_i   (accept),
      .strb_o (strb)
   );

   // Shadow word with the current beat dropped into its strobed lane.
   always_comb begin
      merged = shadow_q;
      for (int i = 0; i < RATIO; i++) begin
         if (strb[i]) merged[i*APB_DW +: APB_DW] = bus.i_PRDATA;
      end
   end

   // Beat count for the requested size: at least one, never more than fits the word.
   always_comb begin
      beats_int = hsize_bytes(bus.i_hsize) / APB_DW_B;
      if (beats_int < 1)     beats_int = 1;
      if (beats_int > RATIO) beats_int = RATIO;
      start_beats = REM_W'(beats_int);
   end

   // Next-state and next-output logic for the collect FSM.
   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      rem_d    = rem_q;
      err_d    = err_q;
      shadow_d = shadow_q;
      hrdata_d = hrdata_q;
      valid_d  = 1'b0;
      rerr_d   = 1'b0;
      abort_d  = 1'b0;
      end_xfer = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_start) begin
               state_d  = ST_COLLECT;
               rem_d    = start_beats;
               lane_d   = (RATIO > 1) ? bus.i_haddr_lane : '0;
               err_d    = 1'b0;
               shadow_d = '0;
            end
         end
         ST_COLLECT: begin
            if (accept) begin
               shadow_d = merged;
               lane_d   = (lane_q == LANE_W'(RATIO - 1)) ? '0 : lane_q + 1'b1;
               rem_d    = rem_q - 1'b1;
               err_d    = err_q | bus.i_PSLVERR;
               end_xfer = (rem_q == REM_W'(1));
`ifdef APB_RDATA_ERR_ABORT_EN
               // An errored beat closes the word immediately with the lanes seen so far.
               if (bus.i_PSLVERR) begin
                  abort_d  = 1'b1;
                  end_xfer = 1'b1;
               end
`endif
               if (end_xfer) begin
                  hrdata_d = merged;
                  valid_d  = 1'b1;
                  rerr_d   = err_q | bus.i_PSLVERR;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Lane/count/shadow tracking and the registered AHB-side outputs.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         lane_q   <= '0;
         rem_q    <= '0;
         err_q    <= 1'b0;
         shadow_q <= '0;
         hrdata_q <= '0;
         valid_q  <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         lane_q   <= lane_d;
         rem_q    <= rem_d;
         err_q    <= err_d;
         shadow_q <= shadow_d;
         hrdata_q <= hrdata_d;
         valid_q  <= valid_d;
         rerr_q   <= rerr_d;
      end
   end

`ifdef APB_RDATA_ERR_ABORT_EN
   logic abort_q;

   // Abort request pulse, aligned with the valid pulse of the truncated word.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) abort_q <= 1'b0;
      else          abort_q <= abort_d;
   end

   assign bus.o_abort = abort_q;
`else
   assign bus.o_abort = 1'b0;
`endif

   assign bus.o_HRDATA      = hrdata_q;
   assign bus.o_rdata_valid = valid_q;
   assign bus.o_rdata_err   = rerr_q;
   assign bus.o_busy        = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_apb_rdata_packer.sv
// Directed plus randomized reads against a word-level reference model of the packer.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_apb_rdata_packer;
   localparam int AHB_DW   = 32;
   localparam int APB_DW   = 8;
   localparam int APB_DW_B = APB_DW / 8;
   localparam int RATIO    = AHB_DW / APB_DW;

   logic PCLK;
   logic PRESETn;
   int   checks;
   int   errors;

   logic [7:0] bd [4];
   int         bw [4];
   bit         be [4];

   apb_rdata_packer_if #(.AHB_DW(AHB_DW), .APB_DW(APB_DW)) bus();

   apb_rdata_packer #(.AHB_DW(AHB_DW), .APB_DW(APB_DW)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Word-level model: which lanes a read fills, what the word looks like, how it ends.
   task automatic model(input logic [2:0] hs, input int ln, output int na,
                        output logic [31:0] w, output bit er, output bit ab);
      int nb;
      nb = (1 << hs) / APB_DW_B;
      if (nb < 1)     nb = 1;
      if (nb > RATIO) nb = RATIO;
      w  = 32'h0;
      er = 1'b0;
      ab = 1'b0;
      na = nb;
      for (int k = 0; k < nb; k++) begin
         w[((ln + k) % RATIO) * APB_DW +: APB_DW] = bd[k];
         er = er | be[k];
`ifdef APB_RDATA_ERR_ABORT_EN
         if (be[k]) begin
            ab = 1'b1;
            na = k + 1;
            break;
         end
`endif
      end
   endtask

   task automatic bus_idle();
      bus.i_start   = 1'b0;
      bus.i_PSEL    = 1'b0;
      bus.i_PENABLE = 1'b0;
      bus.i_PWRITE  = 1'b0;
      bus.i_PREADY  = 1'b0;
      bus.i_PSLVERR = 1'b0;
   endtask

   // Runs one read starting now (caller sits just after a clock edge).
   // rst_after > 0 pulses reset after that many beats; b2b skips the trailing idle cycle.
   task automatic run_read(input logic [2:0] hs, input int ln, input bit noise,
                           input int rst_after, input bit b2b);
      int          na;
      logic [31:0] exp_w;
      bit          exp_e;
      bit          exp_a;
      model(hs, ln, na, exp_w, exp_e, exp_a);
      bus.i_start      = 1'b1;
      bus.i_hsize      = hs;
      bus.i_haddr_lane = ln[1:0];
      @(posedge PCLK); #1;
      bus.i_start = 1'b0;
      chk("busy_after_start", {31'h0, bus.o_busy}, 32'h1);
      for (int k = 0; k < na; k++) begin
         if (noise) begin
            bus.i_PSEL       = 1'b1;
            bus.i_PENABLE    = 1'b1;
            bus.i_PWRITE     = 1'b1;
            bus.i_PREADY     = 1'b1;
            bus.i_PSLVERR    = 1'b1;
            bus.i_PRDATA     = 8'hEE;
            bus.i_start      = 1'b1;
            bus.i_hsize      = 3'd0;
            bus.i_haddr_lane = ~ln[1:0];
            @(posedge PCLK); #1;
            bus_idle();
            chk("noise_no_valid", {31'h0, bus.o_rdata_valid}, 32'h0);
            chk("noise_busy", {31'h0, bus.o_busy}, 32'h1);
         end
         bus.i_PSEL    = 1'b1;
         bus.i_PENABLE = 1'b0;
         bus.i_PWRITE  = 1'b0;
         bus.i_PREADY  = 1'b1;
         bus.i_PRDATA  = 8'($urandom);
         @(posedge PCLK); #1;
         bus.i_PENABLE = 1'b1;
         bus.i_PREADY  = 1'b0;
         bus.i_PRDATA  = bd[k];
         bus.i_PSLVERR = be[k];
         for (int j = 0; j < bw[k]; j++) begin
            @(posedge PCLK); #1;
            chk("wait_no_valid", {31'h0, bus.o_rdata_valid}, 32'h0);
            chk("wait_busy", {31'h0, bus.o_busy}, 32'h1);
         end
         bus.i_PREADY = 1'b1;
         @(posedge PCLK); #1;
         bus_idle();
         if (rst_after > 0 && k == rst_after - 1) begin
            PRESETn = 1'b0;
            #1;
            chk("rst_hrdata", bus.o_HRDATA, 32'h0);
            chk("rst_valid", {31'h0, bus.o_rdata_valid}, 32'h0);
            chk("rst_err", {31'h0, bus.o_rdata_err}, 32'h0);
            chk("rst_busy", {31'h0, bus.o_busy}, 32'h0);
            chk("rst_abort", {31'h0, bus.o_abort}, 32'h0);
            @(posedge PCLK); #1;
            PRESETn = 1'b1;
            bus.i_PSEL    = 1'b1;
            bus.i_PENABLE = 1'b1;
            bus.i_PREADY  = 1'b1;
            bus.i_PRDATA  = 8'h77;
            @(posedge PCLK); #1;
            bus_idle();
            chk("post_rst_no_valid", {31'h0, bus.o_rdata_valid}, 32'h0);
            chk("post_rst_idle", {31'h0, bus.o_busy}, 32'h0);
            chk("post_rst_hrdata", bus.o_HRDATA, 32'h0);
            return;
         end
         if (k == na - 1) begin
            chk("last_valid", {31'h0, bus.o_rdata_valid}, 32'h1);
            chk("last_hrdata", bus.o_HRDATA, exp_w);
            chk("last_err", {31'h0, bus.o_rdata_err}, {31'h0, exp_e});
            chk("last_abort", {31'h0, bus.o_abort}, {31'h0, exp_a});
            chk("last_busy", {31'h0, bus.o_busy}, 32'h0);
         end else begin
            chk("mid_no_valid", {31'h0, bus.o_rdata_valid}, 32'h0);
            chk("mid_busy", {31'h0, bus.o_busy}, 32'h1);
         end
      end
      if (!b2b) begin
         @(posedge PCLK); #1;
         chk("hold_valid_low", {31'h0, bus.o_rdata_valid}, 32'h0);
         chk("hold_err_low", {31'h0, bus.o_rdata_err}, 32'h0);
         chk("hold_abort_low", {31'h0, bus.o_abort}, 32'h0);
         chk("hold_hrdata", bus.o_HRDATA, exp_w);
      end
   endtask

   task automatic set_beats(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
      bd[0] = d0; bd[1] = d1; bd[2] = d2; bd[3] = d3;
      for (int i = 0; i < 4; i++) begin
         bw[i] = 0;
         be[i] = 1'b0;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      PRESETn          = 1'b0;
      bus.i_hsize      = 3'd0;
      bus.i_haddr_lane = 2'd0;
      bus.i_PRDATA     = 8'h00;
      bus_idle();
      repeat (2) @(posedge PCLK);
      #1;
      chk("reset_hrdata", bus.o_HRDATA, 32'h0);
      chk("reset_valid", {31'h0, bus.o_rdata_valid}, 32'h0);
      chk("reset_err", {31'h0, bus.o_rdata_err}, 32'h0);
      chk("reset_busy", {31'h0, bus.o_busy}, 32'h0);
      chk("reset_abort", {31'h0, bus.o_abort}, 32'h0);
      PRESETn = 1'b1;
      @(posedge PCLK); #1;

      // Word read, four back-to-back beats from lane 0.
      set_beats(8'h11, 8'h22, 8'h33, 8'h44);
      run_read(3'd2, 0, 1'b0, 0, 1'b0);

      // Same read with three wait states on the second beat.
      set_beats(8'h11, 8'h22, 8'h33, 8'h44);
      bw[1] = 3;
      run_read(3'd2, 0, 1'b0, 0, 1'b0);

      // Byte read into the top lane.
      set_beats(8'hA5, 8'h00, 8'h00, 8'h00);
      run_read(3'd0, 3, 1'b0, 0, 1'b0);

      // Halfword read starting at lane 3 wraps to lane 0.
      set_beats(8'h5A, 8'hC3, 8'h00, 8'h00);
      run_read(3'd1, 3, 1'b0, 0, 1'b0);

      // Slave error on the second beat of four.
      set_beats(8'h11, 8'h22, 8'h33, 8'h44);
      be[1] = 1'b1;
      run_read(3'd2, 0, 1'b0, 0, 1'b0);

      // Reset mid-transfer, then a clean read.
      set_beats(8'h11, 8'h22, 8'h33, 8'h44);
      run_read(3'd2, 0, 1'b0, 2, 1'b0);
      set_beats(8'h99, 8'h88, 8'h77, 8'h66);
      run_read(3'd2, 1, 1'b0, 0, 1'b0);

      // Stray starts and write beats during collection.
      set_beats(8'h01, 8'h02, 8'h03, 8'h04);
      run_read(3'd2, 2, 1'b1, 0, 1'b0);

      // Back-to-back reads with no bubble, then an oversize read saturating at the word.
      set_beats(8'hDE, 8'hAD, 8'hBE, 8'hEF);
      run_read(3'd2, 0, 1'b0, 0, 1'b1);
      set_beats(8'hCA, 8'hFE, 8'hF0, 8'h0D);
      run_read(3'd3, 1, 1'b0, 0, 1'b0);

      // Randomized reads.
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 4; i++) begin
            bd[i] = 8'($urandom);
            bw[i] = int'($urandom_range(0, 3));
            be[i] = ($urandom_range(0, 7) == 0);
         end
         run_read(3'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)), 0, bit'($urandom_range(0, 1)));
      end

      @(posedge PCLK); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_rdata_packer.md
# apb_rdata_packer

Read-data assembly stage downstream of the APB master FSM in the AHB-to-APB bridge. It observes the APB bus during a read transfer, captures each completed APB_DW-wide PRDATA beat into the correct byte lane of an AHB_DW-wide holding register, and presents the assembled word with a one-cycle valid pulse and an accumulated error flag to the AHB side. It runs entirely in the PCLK domain and owns the bridge's HRDATA register.

## Interface
- AHB_DW, 32, AHB data width in bits; multiple of APB_DW.
- APB_DW, 8, APB data width in bits; 8, 16 or 32.
- Derived: APB_DW_B = APB_DW/8; RATIO = AHB_DW/APB_DW; LANE_W = clog2(RATIO), minimum 1.

- PCLK  in  1  APB clock.
- PRESETn  in  1  Reset: PRESETn, asynchronous, active-low; clock PCLK.
- i_start  in  1  Read transfer request; sampled only in IDLE.
- i_hsize  in  3  AHB HSIZE of the read, sampled with i_start.
- i_haddr_lane  in  LANE_W  Starting APB lane (HADDR bits above the APB byte offset), sampled with i_start.
- i_PSEL, i_PENABLE, i_PWRITE, i_PREADY, i_PSLVERR  in  1 each  APB bus observed.
- i_PRDATA  in  APB_DW  APB read data.
- o_HRDATA  out  AHB_DW  Assembled read word.
- o_rdata_valid  out  1  One-cycle pulse: o_HRDATA holds a complete word.
- o_rdata_err  out  1  PSLVERR seen on any beat of the word; valid with o_rdata_valid.
- o_busy  out  1  High in COLLECT.
- o_abort  out  1  One-cycle pulse requesting early termination (macro-dependent).

## Operation
- States: IDLE, COLLECT. Encoding 1 bit, IDLE = 0.
- IDLE: on i_start=1, compute beats = max(1, bytes(i_hsize)/APB_DW_B), saturated at RATIO; load r_remaining = beats, r_lane = i_haddr_lane, clear r_err, clear shadow word to 0; go COLLECT.
- Beat accept: COLLECT and i_PSEL & i_PENABLE & i_PREADY & ~i_PWRITE. Write beats (i_PWRITE=1) and wait cycles (i_PREADY=0) are ignored.
- On accept: shadow[r_lane*APB_DW +: APB_DW] <= i_PRDATA; r_lane <= r_lane+1 mod RATIO (wrap); r_remaining <= r_remaining-1; r_err |= i_PSLVERR.
- Last beat (r_remaining==1 at accept): o_HRDATA <= shadow with this beat merged; o_rdata_valid <= 1; o_rdata_err <= r_err | i_PSLVERR; go IDLE.
- Lanes not written during the transfer read as 0 in o_HRDATA.
- i_start in COLLECT is ignored; no queuing.
- RATIO==1: single beat, lane index constant 0.
- Reset values: o_HRDATA=0, o_rdata_valid=0, o_rdata_err=0, o_busy=0, o_abort=0, state IDLE, all counters 0.
- PRESETn asserted mid-transfer: immediate return to IDLE, partial shadow discarded, no valid pulse after release.

## Timing
- i_start at edge N -> o_busy=1 from cycle N+1.
- Last beat accepted at edge M -> o_HRDATA, o_rdata_valid, o_rdata_err update at M; visible cycle M+1 only for the pulse; o_busy=0 in M+1.
- i_start accepted again at edge M+1 earliest (back-to-back reads, zero bubble).
- o_HRDATA holds its value until the next last-beat edge.
- o_rdata_err high only in the o_rdata_valid cycle; cleared otherwise.

## Configuration
- APB_RDATA_ERR_ABORT_EN defined: a beat accepted with i_PSLVERR=1 ends the transfer at once: o_abort pulses 1 cycle, o_rdata_valid and o_rdata_err=1 pulse at the same edge, remaining lanes left 0, state to IDLE.
- Undefined: o_abort tied 0; error is sticky, all beats are collected, error reported with the final valid.

## Structure
- Shared package apb_bridge_pkg: state enum, clog2 function, hsize-to-bytes function (reused by the APB master FSM byte decoder).
- One sub-module: rdata_lane_demux (lane index + enable -> RATIO one-hot write strobes), parameterised by RATIO/LANE_W.

## Test plan
- AHB_DW=32, APB_DW=8, hsize=2, lane 0, PRDATA 0x11,0x22,0x33,0x44 with no waits -> o_HRDATA=0x44332211, one valid pulse, err=0.
- Same, i_PREADY low 3 cycles on beat 2 -> identical result, valid delayed 3 cycles, o_busy held.
- hsize=0, lane 3, PRDATA 0xA5 -> o_HRDATA=0xA5000000; hsize=1, lane 3 -> beats at lanes 3,0 (wrap).
- PSLVERR on beat 2 of 4: macro off -> 4 beats, err=1 with valid; macro on -> o_abort and valid at beat 2, o_HRDATA=0x00002211.
- PRESETn pulsed after beat 2 -> all outputs 0, no valid; next read assembles cleanly.
- i_start during COLLECT and write beats with PWRITE=1 -> ignored, no lane change.
